// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefBlock = 8;
  localparam int unsigned MaxWidth = 256;

  function automatic int unsigned cla_ngrp(int unsigned width, int unsigned block);
    return width / block;
  endfunction

  // Most positive signed value of the given width, zero-extended to MaxWidth.
  function automatic logic [MaxWidth-1:0] sat_pos(int unsigned width);
    logic [MaxWidth-1:0] v;
    v = '0;
    for (int i = 0; i < MaxWidth; i++) begin
      if (i < int'(width) - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [MaxWidth-1:0] sat_neg(int unsigned width);
    logic [MaxWidth-1:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result handshake bundle; in_sat exists only when CLA_SATURATE_EN is defined.
interface pipelined_cla_addsub_if
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sub;
  logic             in_cin;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
`ifdef CLA_SATURATE_EN
  logic             in_sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
`ifdef CLA_SATURATE_EN
    output in_sat,
`endif
    output in_valid, in_sub, in_cin, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
`ifdef CLA_SATURATE_EN
    input  in_sat,
`endif
    input  in_valid, in_sub, in_cin, in_x, in_y, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/cla_group.sv
// Combinational BLOCK-bit carry-lookahead group: every carry is a flat G/P sum of products.
module cla_group #(
  parameter int unsigned BLOCK = 8
) (
  input  logic [BLOCK-1:0] x_i,
  input  logic [BLOCK-1:0] y_i,
  input  logic             cin_i,
  output logic [BLOCK-1:0] sum_o,
  output logic             g_o,
  output logic             p_o,
  output logic             cout_o,
  output logic             cmsb_o
);
  logic [BLOCK-1:0] g, p;
  logic [BLOCK:0]   c;
  logic             acc, prod;

  assign g = x_i & y_i;
  assign p = x_i ^ y_i;

  // c[i] = cin&p[0..i-1] | OR_j g[j]&p[j+1..i-1]; g_o is the same expansion with cin = 0.
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    prod = 1'b0;
    g_o  = 1'b0;
    c[0] = cin_i;
    for (int i = 1; i <= int'(BLOCK); i++) begin
      prod = cin_i;
      for (int j = 0; j < i; j++) prod = prod & p[j];
      acc = prod;
      for (int j = 0; j < i; j++) begin
        prod = g[j];
        for (int m = j + 1; m < i; m++) prod = prod & p[m];
        acc = acc | prod;
      end
      c[i] = acc;
    end
    for (int j = 0; j < int'(BLOCK); j++) begin
      prod = g[j];
      for (int m = j + 1; m < int'(BLOCK); m++) prod = prod & p[m];
      g_o = g_o | prod;
    end
  end

  assign sum_o  = p ^ c[BLOCK-1:0];
  assign p_o    = &p;
  assign cout_o = c[BLOCK];
  assign cmsb_o = c[BLOCK-1];
endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined CLA adder/subtractor, one BLOCK-bit group per stage; CLA_SATURATE_EN adds clamping.
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned BLOCK = DefBlock
) (
  input logic                   clock,
  input logic                   reset,
  pipelined_cla_addsub_if.slave bus
);
  localparam int unsigned NGRP = cla_ngrp(WIDTH, BLOCK);

  logic                             adv;
  logic [NGRP-1:0][WIDTH-1:0]       op_x, op_y, part_sum, sum_d, sum_q, x_q, y_q;
  logic [NGRP-1:0][BLOCK-1:0]       grp_sum;
  logic [NGRP-1:0]                  vld_in, cin, c_d, vld_q, c_q;
  logic [NGRP-1:0]                  grp_g, grp_p, grp_cout, grp_cmsb;
  logic                             ovf_d, ovf_q;
  logic                             unused_sig;
`ifdef CLA_SATURATE_EN
  localparam logic [MaxWidth-1:0] SatPosFull = sat_pos(WIDTH);
  localparam logic [MaxWidth-1:0] SatNegFull = sat_neg(WIDTH);
  localparam logic [WIDTH-1:0]    SatPos     = SatPosFull[WIDTH-1:0];
  localparam logic [WIDTH-1:0]    SatNeg     = SatNegFull[WIDTH-1:0];
  logic [NGRP-1:0]                sat_in, sat_q;
  logic                           unused_sat;
  assign unused_sat = sat_q[NGRP-1];
`endif

  // A full output register that nobody takes freezes the whole pipe.
  assign adv          = ~vld_q[NGRP-1] | bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < NGRP; k++) begin : g_stage
    logic [WIDTH-1:0] merged;

    if (k == 0) begin : g_in
      assign op_x[k]     = bus.in_x;
      assign op_y[k]     = bus.in_sub ? ~bus.in_y : bus.in_y;
      assign cin[k]      = bus.in_sub | bus.in_cin;
      assign part_sum[k] = '0;
      assign vld_in[k]   = bus.in_valid;
`ifdef CLA_SATURATE_EN
      assign sat_in[k]   = bus.in_sat;
`endif
    end else begin : g_pipe
      assign op_x[k]     = x_q[k-1];
      assign op_y[k]     = y_q[k-1];
      assign cin[k]      = c_q[k-1];
      assign part_sum[k] = sum_q[k-1];
      assign vld_in[k]   = vld_q[k-1];
`ifdef CLA_SATURATE_EN
      assign sat_in[k]   = sat_q[k-1];
`endif
    end

    cla_group #(
      .BLOCK (BLOCK)
    ) u_grp (
      .x_i    (op_x[k][k*BLOCK +: BLOCK]),
      .y_i    (op_y[k][k*BLOCK +: BLOCK]),
      .cin_i  (cin[k]),
      .sum_o  (grp_sum[k]),
      .g_o    (grp_g[k]),
      .p_o    (grp_p[k]),
      .cout_o (grp_cout[k]),
      .cmsb_o (grp_cmsb[k])
    );

    always_comb begin
      merged                     = part_sum[k];
      merged[k*BLOCK +: BLOCK] = grp_sum[k];
    end

    assign c_d[k] = grp_g[k] | (grp_p[k] & cin[k]);

    if (k == NGRP - 1) begin : g_last
`ifdef CLA_SATURATE_EN
      // On overflow both operands share a sign, and that sign is the true result's sign.
      assign sum_d[k] = (sat_in[k] && ovf_d) ? (op_x[k][WIDTH-1] ? SatNeg : SatPos) : merged;
`else
      assign sum_d[k] = merged;
`endif
    end else begin : g_mid
      assign sum_d[k] = merged;
    end
  end

  assign ovf_d = grp_cmsb[NGRP-1] ^ grp_cout[NGRP-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      c_q   <= '0;
      sum_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      ovf_q <= 1'b0;
`ifdef CLA_SATURATE_EN
      sat_q <= '0;
`endif
    end else if (adv) begin
      vld_q <= vld_in;
      for (int k = 0; k < int'(NGRP); k++) begin
        if (vld_in[k]) begin
          sum_q[k] <= sum_d[k];
          c_q[k]   <= c_d[k];
          x_q[k]   <= op_x[k];
          y_q[k]   <= op_y[k];
`ifdef CLA_SATURATE_EN
          sat_q[k] <= sat_in[k];
`endif
        end
      end
      if (vld_in[NGRP-1]) ovf_q <= ovf_d;
    end
  end

  assign bus.out_valid = vld_q[NGRP-1];
  assign bus.out_sum   = sum_q[NGRP-1];
  assign bus.out_cout  = c_q[NGRP-1];
  assign bus.out_ovf   = ovf_q;

  // Only group k and the MSB of each operand copy are consumed downstream.
  assign unused_sig = ^{x_q, y_q, op_x, op_y, grp_cout, grp_cmsb};
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub (WIDTH 32, BLOCK 8); honours CLA_SATURATE_EN.
module tb_pipelined_cla_addsub;
  localparam int unsigned W  = 32;
  localparam int unsigned NG = 4;
`ifdef CLA_SATURATE_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned last_pop_cyc = 0;
  int unsigned n_pops = 0;
  int unsigned acc_cyc = 0;
  res_t        exp_q[$];
  res_t        mon_r;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_cla_addsub_if #(.WIDTH(W)) bus ();

  pipelined_cla_addsub #(
    .WIDTH (W),
    .BLOCK (8)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic sub, input logic cin, input logic sat);
    res_t       r;
    logic [W-1:0] ye;
    logic [W:0] full;
    ye     = sub ? ~y : y;
    full   = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, (sub | cin)};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (x[W-1] == ye[W-1]) && (r.sum[W-1] != x[W-1]);
    if (SatEn && sat && r.ovf) r.sum = x[W-1] ? 32'h8000_0000 : 32'h7fff_ffff;
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub,
                         input logic cin, input logic sat, input bit track);
    logic rdy;
    bit   acc;
    acc          = 1'b0;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_sub   = sub;
    bus.in_cin   = cin;
`ifdef CLA_SATURATE_EN
    bus.in_sat   = sat;
`endif
    bus.in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    check_eq("accepted", 64'(acc), 64'd1);
    acc_cyc = cyc;
    if (acc && track) exp_q.push_back(model(x, y, sub, cin, sat));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    check_eq("drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic single(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub,
                        input logic cin, input logic sat);
    int lat;
    lat = 0;
    send_op(x, y, sub, cin, sat, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      lat = i;
      if (bus.out_valid) break;
    end
    check_eq("latency", 64'(lat), 64'(NG));
    wait_drain();
  endtask

  // Scoreboard: pop on every output handshake; with nothing expected, out_valid must stay low.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() == 0) begin
        check_eq("no_stale_valid", 64'(bus.out_valid), 64'd0);
      end else if (bus.out_valid && bus.out_ready) begin
        mon_r = exp_q.pop_front();
        check_eq("sum", 64'(bus.out_sum), 64'(mon_r.sum));
        check_eq("cout", 64'(bus.out_cout), 64'(mon_r.cout));
        check_eq("ovf", 64'(bus.out_ovf), 64'(mon_r.ovf));
        last_pop_cyc = cyc;
        n_pops++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned first_acc;
    int unsigned pops_before;
    logic [W-1:0] stall_sum;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_sub    = 1'b0;
    bus.in_cin    = 1'b0;
`ifdef CLA_SATURATE_EN
    bus.in_sat    = 1'b0;
`endif
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_out_sum", 64'(bus.out_sum), 64'd0);
    check_eq("rst_out_cout", 64'(bus.out_cout), 64'd0);
    check_eq("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("in_ready_after_rst", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed vectors, each with an exact latency check.
    single(32'h0000_00ff, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    single(32'hffff_ffff, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    single(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 1'b0);
    single(32'h7fff_ffff, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    single(32'h1234_5678, 32'h0fed_cba9, 1'b0, 1'b1, 1'b0);
    single(32'h0000_0007, 32'h0000_0007, 1'b1, 1'b1, 1'b0);
    single(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    single(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
    single(32'h7fff_fff0, 32'h0000_0100, 1'b0, 1'b0, 1'b1);

    // Back-to-back stream: one result per cycle, in order.
    first_acc = 0;
    for (int i = 0; i < 16; i++) begin
      send_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b1);
      if (i == 0) first_acc = acc_cyc;
    end
    wait_drain();
    check_eq("stream_span", 64'(last_pop_cyc - first_acc), 64'(15 + NG - 1));

    // Backpressure mid-stream.
    pops_before = n_pops;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          send_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'b0, 1'b1);
        end
      end
      begin
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        stall_sum = bus.out_sum;
        check_eq("stall_out_valid", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check_eq("stall_in_ready", 64'(bus.in_ready), 64'd0);
          check_eq("stall_sum_stable", 64'(bus.out_sum), 64'(stall_sum));
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    check_eq("bp_result_count", 64'(n_pops - pops_before), 64'd12);

    // Reset with three untracked operations in flight: none may emerge.
    send_op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b0);
    send_op(32'h3333_3333, 32'h4444_4444, 1'b1, 1'b0, 1'b0, 1'b0);
    send_op(32'h5555_5555, 32'h6666_6666, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_flush_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("in_ready_after_midrst", 64'(bus.in_ready), 64'd1);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    single(32'h0000_ffff, 32'h0000_0001, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the multdiv datapath and ALU.
- Operands split into BLOCK-bit groups; one group resolved per pipeline stage with the inter-group carry registered.
- Throughput one operation per cycle, with valid/ready backpressure.
- Outputs sum, carry-out and signed overflow.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of BLOCK.
- BLOCK, 8, group width resolved per stage by the lookahead logic.
- NGRP, WIDTH/BLOCK, derived localparam: number of pipeline stages, equal to latency in cycles.

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand presented this cycle.
- in_ready  output  1  block can accept operand this cycle.
- in_sub  input  1  0 = x+y+in_cin; 1 = x-y (y inverted, carry-in forced 1, in_cin ignored).
- in_x  input  WIDTH  operand x.
- in_y  input  WIDTH  operand y.
- in_cin  input  1  carry-in for add mode.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  result.
- out_cout  output  1  carry out of MSB; in sub mode 1 means no borrow.
- out_ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: all stage valid bits, out_valid, out_sum, out_cout, out_ovf = 0. Reset mid-operation discards every in-flight operation; in_ready = 1 on the cycle after reset deasserts.
- Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational). When adv = 0, all pipeline registers hold.
- Accept occurs when in_valid && in_ready. Stage 0 then registers the group-0 sum, carry out of group 0, the upper (un-summed) operand groups of x and effective y, and the sub flag.
- Stage k (1..NGRP-1) adds group k using the registered carry. Lower result groups are delayed through skew registers; upper operand groups pass through.
- Latency is exactly NGRP cycles from accept to out_valid with no stall. With WIDTH = 32 and BLOCK = 8, an operand accepted at edge n appears at edge n+3 (out_valid high after the 4th stage edge).
- Bubbles propagate as valid = 0; register contents of invalid stages are don't-care, but out_sum holds its last value while out_valid = 0.
- Simultaneous accept and output handshake in the same cycle: both occur, and full throughput is sustained.
- Each group's adder is a full lookahead (group G/P plus per-bit carries); no ripple inside a group.
- Arithmetic is modulo 2^WIDTH. out_ovf is computed in both modes.
- NGRP = 1 degenerates to a single registered stage with latency 1.

Optional Feature:
- Macro: CLA_SATURATE_EN.
- Defined: extra input in_sat (1 bit) is carried alongside the operation. If in_sat = 1 and signed overflow occurs, out_sum is clamped to 0x7FF..F when the true result is positive, or 0x800..0 when negative; out_ovf still reports 1. Clamping is done in the final stage with no added latency.
- Undefined: no in_sat port; result always wraps.

Decomposition:
- Shared package cla_pkg:
  - default WIDTH and BLOCK constants;
  - a function computing NGRP;
  - constants SAT_POS/SAT_NEG as functions of width.
- One sub-module, cla_group: combinational BLOCK-bit lookahead group. Inputs x, y, cin; outputs sum, G, P, cout, carry into MSB. Instantiated once per stage via generate.

Test Plan:
- Add, WIDTH = 32: x = 0x0000_00FF, y = 0x0000_0001, cin = 0 → out_sum = 0x0000_0100, cout = 0, ovf = 0, exactly 4 cycles after accept; also x = 0xFFFF_FFFF, y = 1 → sum = 0, cout = 1, ovf = 0.
- Sub: x = 5, y = 7 → out_sum = 0xFFFF_FFFE, cout = 0 (borrow), ovf = 0. Signed overflow: x = 0x7FFF_FFFF + y = 1 → sum = 0x8000_0000, ovf = 1.
- Back-to-back stream of 16 random operations with out_ready held 1 → one result per cycle, in order, each matching a reference model.
- Backpressure: out_ready = 0 for 5 cycles mid-stream → in_ready = 0 during the stall, no result lost or duplicated, out_sum stable while stalled.
- Reset asserted with 3 operations in flight → out_valid = 0 on the next cycle, no stale result ever emitted; a new operation afterwards completes with latency 4.
- CLA_SATURATE_EN: in_sat = 1, x = 0x8000_0000 minus y = 1 → out_sum = 0x8000_0000, ovf = 1; with in_sat = 0 → 0x7FFF_FFFF.
